// File: rtl/mult_core_if.sv
// Handshake and operand/result bundle for the sequential Q16.16 multiplier.
interface mult_core_if;
  logic        start;
  logic [15:0] quo;
  logic [15:0] frac;
  logic [15:0] mul;
  logic        rfd;
  logic        done;
  logic [15:0] oup;
  logic [15:0] ofrac;
  logic        ovf;

  modport master (output start, quo, frac, mul,
                  input  rfd, done, oup, ofrac, ovf);
  modport slave  (input  start, quo, frac, mul,
                  output rfd, done, oup, ofrac, ovf);
endinterface

// File: rtl/mult_core.sv
// Shift-add Q16.16 x uint16 multiplier, one multiplier bit per clock, saturating on overflow.
//   state | meaning
//   IDLE  | rfd=1, waiting for start
//   BUSY  | 16 cycles, accumulate M<<i when multiplier bit i is set
//   DONE  | one cycle, done=1, result registers already loaded
module mult_core (
  input logic     clk,
  input logic     rst_n,
  mult_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] mcand;
  logic [15:0] mplr;
  logic [47:0] acc;
  logic [47:0] addend;
  logic [47:0] acc_sum;
  logic [3:0]  idx;
  logic        accept;
  logic        last_bit;
  logic [15:0] oup_q;
  logic [15:0] ofrac_q;
  logic        ovf_q;
  logic        sum_ovf;

  assign accept   = (state == IDLE) && bus.start;
  assign last_bit = (state == BUSY) && (idx == 4'd15);

  // 48-bit datapath: the largest partial sum (2^32-1)*(2^16-1) fits, so no wrap.
  always_comb begin
    addend  = '0;
    if (mplr[idx])
      addend = {16'd0, mcand} << idx;
    acc_sum = acc + addend;
    sum_ovf = |acc_sum[47:32];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = BUSY;
      BUSY:    if (idx == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      idx   <= '0;
    end else if (accept) begin
      mcand <= {bus.quo, bus.frac};
      mplr  <= bus.mul;
      acc   <= '0;
      idx   <= '0;
    end else if (state == BUSY) begin
      acc <= acc_sum;
      idx <= idx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oup_q   <= '0;
      ofrac_q <= '0;
      ovf_q   <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= sum_ovf;
      if (sum_ovf) begin
        oup_q   <= 16'hFFFF;
        ofrac_q <= 16'hFFFF;
      end else begin
        oup_q   <= acc_sum[31:16];
        ofrac_q <= acc_sum[15:0];
      end
    end
  end

  assign bus.rfd   = (state == IDLE);
  assign bus.done  = (state == DONE);
  assign bus.oup   = oup_q;
  assign bus.ofrac = ofrac_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: doc/mult_core.md
# mult_core

Sequential fixed-point multiplier that undoes the divider: it takes a Q16.16 quotient (integer part plus 16-bit fraction, as produced by the division core) and a 16-bit unsigned integer, and returns the Q16.16 product. In the Snell-law datapath it rescales a ratio back by an index or length term. It uses the same ready-for-data style handshake as the divider. A shift-add loop that consumes one multiplier bit per clock keeps area small.

## Interface
- No parameters. Widths are fixed at 16 integer bits, 16 fraction bits and a 16-bit multiplier.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only while rfd=1
- quo  in  16  multiplicand integer part (unsigned)
- frac  in  16  multiplicand fraction part (unsigned, weight 2^-16 per LSB)
- mul  in  16  multiplier, unsigned integer
- rfd  out  1  ready for data; 1 = idle and able to accept start
- done  out  1  one-cycle pulse; result valid
- oup  out  16  product integer part
- ofrac  out  16  product fraction part
- ovf  out  1  product integer part exceeded 16 bits (result saturated)

## Operation
- States:
  - IDLE: rfd=1. If start=1, go to BUSY.
  - BUSY: 16 cycles, one per multiplier bit.
  - DONE: 1 cycle, done=1. Always returns to IDLE.
- Accept (IDLE, start=1 at a rising edge):
  - latch M={quo,frac} (32 bits) and the multiplier into internal registers;
  - clear the 48-bit accumulator and set bit counter i=0;
  - drop rfd.
- BUSY, each edge:
  - if multiplier bit i is 1, then acc += M<<i, computed at 48 bits so it can never wrap;
  - i increments. The transition to DONE happens on the edge that processes i=15.
- On the BUSY→DONE edge, register the outputs:
  - ovf = |acc[47:32];
  - if ovf=0: oup=acc[31:16], ofrac=acc[15:0];
  - if ovf=1: oup=16'hFFFF, ofrac=16'hFFFF.
- The result is exact. The multiplier is an integer, so no rounding is needed.
- oup, ofrac and ovf hold their value until the next DONE edge or reset.
- start while rfd=0 is ignored. The request is dropped, not queued.
- Operand inputs are only sampled on the accept edge. Changing them during BUSY has no effect.
- mul=0 or M=0: still takes the full 16 cycles; result 0, ovf=0.
- Reset values: rfd=1, done=0, oup=0, ofrac=0, ovf=0, state IDLE, accumulator and counter cleared.
- rst_n low at any time, including mid-BUSY or in DONE:
  - aborts immediately and forces the reset values asynchronously;
  - no done pulse is produced for the aborted operation.

## Timing
- Call the accepting edge E0.
- rfd goes low right after E0.
- BUSY edges are E1..E16. The E16 edge moves to DONE and registers the outputs.
- done=1 in the cycle after E16, so the latency is 16 cycles from acceptance to a visible result. done is high for exactly one cycle.
- E17 returns to IDLE and raises rfd. The earliest next accept is E18.
- Throughput is one operation per 18 cycles.
- start asserted in the same cycle rfd rises is accepted on the following edge.

## Test plan
- Basic multiply: quo=5, frac=0, mul=2 → done 16 cycles after accept; oup=10, ofrac=0, ovf=0; rfd low throughout BUSY and DONE.
- Divider round-trip: quo=3, frac=16'h5555, mul=3 → oup=9, ofrac=16'hFFFF, ovf=0. Also quo=0, frac=16'h8000, mul=8 → oup=4, ofrac=0.
- Overflow: quo=16'h8000, frac=0, mul=2 → ovf=1, oup=16'hFFFF, ofrac=16'hFFFF. A following run with quo=1, frac=0, mul=1 → ovf=0, oup=1.
- Handshake:
  - pulse start with new operands mid-BUSY → no effect on the result; exactly one done pulse;
  - hold start high continuously → accepts occur every 18 cycles.
- Zero operands: mul=0 with quo=16'hFFFF, and quo=0, frac=0 with mul=16'hFFFF → full latency; oup=0, ofrac=0, ovf=0.
- Reset:
  - drop rst_n 8 cycles into BUSY → outputs immediately return to the reset values without waiting for a clock; no done pulse;
  - after release, a fresh 5×2 operation returns 10 correctly.
